// File: rtl/or_event_catcher_if.sv
`default_nettype none
// ============================================================================
// Module      : or_event_catcher_if
// Description : Bus bundle between the OR-gate event catcher and the control
//               logic that consumes its request and event count.
// Revision    : 1.0 - initial release
// ============================================================================
interface or_event_catcher_if #(
  parameter int CNT_W = 8
);

  logic             y_in;      // raw OR-gate output, asynchronous to clk
  logic             ack;       // consumer acknowledge, synchronous
  logic             clr;       // synchronous clear of count and overflow
  logic             y_sync;    // last synchroniser stage
  logic             y_filt;    // debounced level
  logic             req;       // pending-event request
  logic [CNT_W-1:0] count;     // saturating count of accepted rising events
  logic             overflow;  // sticky saturation flag

  // Consumer / stimulus side
  modport master (
    output y_in,
    output ack,
    output clr,
    input  y_sync,
    input  y_filt,
    input  req,
    input  count,
    input  overflow
  );

  // Catcher side
  modport slave (
    input  y_in,
    input  ack,
    input  clr,
    output y_sync,
    output y_filt,
    output req,
    output count,
    output overflow
  );

endinterface
`default_nettype wire

// File: rtl/or_event_catcher.sv
`default_nettype none
// ============================================================================
// Module      : or_event_catcher
// Description : Synchronises and debounces the asynchronous OR-gate output,
//               turns each debounced rising edge into an event, holds a
//               level request until acknowledged and keeps a saturating
//               event count with a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module or_event_catcher #(
  parameter int SYNC_STAGES = 2,  // synchroniser depth, 2..4
  parameter int FILT_LEN    = 3,  // equal samples needed to change y_filt, 1..15
  parameter int CNT_W       = 8   // event counter width, 2..16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  or_event_catcher_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_LOW      = 2'd0;
  localparam logic [1:0] c_RISE_CHK = 2'd1;
  localparam logic [1:0] c_HIGH     = 2'd2;
  localparam logic [1:0] c_FALL_CHK = 2'd3;

  // Last count value before the filter accepts a new level
  localparam logic [3:0]       c_FC_LAST = 4'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Synchroniser
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] w_sync_d;
  logic                   w_ys;

  // Stage 0 samples the raw pin; every later stage samples its predecessor.
  assign w_sync_d[0] = bus.y_in;

  genvar gi;
  for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    assign w_sync_d[gi] = r_sync[gi-1];
  end

  // Shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= w_sync_d;
    end
  end

  assign w_ys = r_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Debounce filter FSM
  // --------------------------------------------------------------------------
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [3:0] r_fc;
  logic [3:0] w_fc_nxt;
  logic       r_filt;
  logic       w_filt_nxt;
  logic       w_event;

  // State register: filter state, run counter and the registered level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_LOW;
      r_fc    <= 4'd0;
      r_filt  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fc    <= w_fc_nxt;
      r_filt  <= w_filt_nxt;
    end
  end

  // Next-state logic: count consecutive samples that disagree with y_filt
  always_comb begin
    w_state_nxt = r_state;
    w_fc_nxt    = r_fc;
    case (r_state)
      c_LOW: begin
        if (w_ys) begin
          if (FILT_LEN == 1) begin
            w_state_nxt = c_HIGH;
            w_fc_nxt    = 4'd0;
          end else begin
            w_state_nxt = c_RISE_CHK;
            w_fc_nxt    = 4'd1;
          end
        end else begin
          w_fc_nxt = 4'd0;
        end
      end
      c_RISE_CHK: begin
        if (!w_ys) begin
          // Run broken: the high pulse was a glitch
          w_state_nxt = c_LOW;
          w_fc_nxt    = 4'd0;
        end else if (r_fc == c_FC_LAST) begin
          w_state_nxt = c_HIGH;
          w_fc_nxt    = 4'd0;
        end else begin
          w_fc_nxt = r_fc + 4'd1;
        end
      end
      c_HIGH: begin
        if (!w_ys) begin
          if (FILT_LEN == 1) begin
            w_state_nxt = c_LOW;
            w_fc_nxt    = 4'd0;
          end else begin
            w_state_nxt = c_FALL_CHK;
            w_fc_nxt    = 4'd1;
          end
        end else begin
          w_fc_nxt = 4'd0;
        end
      end
      c_FALL_CHK: begin
        if (w_ys) begin
          // Run broken: the low pulse was a glitch
          w_state_nxt = c_HIGH;
          w_fc_nxt    = 4'd0;
        end else if (r_fc == c_FC_LAST) begin
          w_state_nxt = c_LOW;
          w_fc_nxt    = 4'd0;
        end else begin
          w_fc_nxt = r_fc + 4'd1;
        end
      end
      default: begin
        w_state_nxt = c_LOW;
        w_fc_nxt    = 4'd0;
      end
    endcase
  end

  // Output decode: an event is any transition from the low side into HIGH;
  // y_filt follows the side of the state being entered.
  always_comb begin
    w_event    = 1'b0;
    w_filt_nxt = 1'b0;
    if ((w_state_nxt == c_HIGH) &&
        ((r_state == c_LOW) || (r_state == c_RISE_CHK))) begin
      w_event = 1'b1;
    end
    if ((w_state_nxt == c_HIGH) || (w_state_nxt == c_FALL_CHK)) begin
      w_filt_nxt = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Request handshake
  // --------------------------------------------------------------------------
  logic r_req;

  // A new event always wins over a coincident acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= 1'b0;
    end else if (w_event) begin
      r_req <= 1'b1;
    end else if (bus.ack) begin
      r_req <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating event counter and sticky overflow
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  // Clear takes priority but still accepts an event on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (bus.clr) begin
      r_cnt <= w_event ? c_CNT_ONE : '0;
      r_ovf <= 1'b0;
    end else if (w_event) begin
      if (r_cnt == c_CNT_MAX) begin
        r_ovf <= 1'b1;
      end else begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.y_sync   = w_ys;
  assign bus.y_filt   = r_filt;
  assign bus.req      = r_req;
  assign bus.count    = r_cnt;
  assign bus.overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_or_event_catcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_or_event_catcher
// Description : Self-checking bench for or_event_catcher. Three instances
//               with different parameters share one random stimulus stream
//               and are compared every cycle against a window-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_or_event_catcher;

  localparam int NI = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic y_in  = 1'b0;
  logic ack   = 1'b0;
  logic clr   = 1'b0;

  always #5 clk = ~clk;

  // Instance parameters: default, FILT_LEN=1, and a small counter variant
  int ss[NI] = '{2, 2, 3};
  int fl[NI] = '{3, 1, 4};
  int cw[NI] = '{8, 8, 2};

  or_event_catcher_if #(.CNT_W(8)) if0 ();
  or_event_catcher_if #(.CNT_W(8)) if1 ();
  or_event_catcher_if #(.CNT_W(2)) if2 ();

  assign if0.y_in = y_in;
  assign if0.ack  = ack;
  assign if0.clr  = clr;
  assign if1.y_in = y_in;
  assign if1.ack  = ack;
  assign if1.clr  = clr;
  assign if2.y_in = y_in;
  assign if2.ack  = ack;
  assign if2.clr  = clr;

  or_event_catcher #(.SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  or_event_catcher #(.SYNC_STAGES(2), .FILT_LEN(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));
  or_event_catcher #(.SYNC_STAGES(3), .FILT_LEN(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave));

  // Gather DUT outputs into arrays for looped checking
  logic       d_sync[NI];
  logic       d_filt[NI];
  logic       d_req[NI];
  logic [7:0] d_cnt[NI];
  logic       d_ovf[NI];

  assign d_sync[0] = if0.y_sync;
  assign d_filt[0] = if0.y_filt;
  assign d_req[0]  = if0.req;
  assign d_cnt[0]  = if0.count;
  assign d_ovf[0]  = if0.overflow;
  assign d_sync[1] = if1.y_sync;
  assign d_filt[1] = if1.y_filt;
  assign d_req[1]  = if1.req;
  assign d_cnt[1]  = if1.count;
  assign d_ovf[1]  = if1.overflow;
  assign d_sync[2] = if2.y_sync;
  assign d_filt[2] = if2.y_filt;
  assign d_req[2]  = if2.req;
  assign d_cnt[2]  = {6'd0, if2.count};
  assign d_ovf[2]  = if2.overflow;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. Every sampled y_in since reset is kept; the filter at
  // edge n accepts a new level v when the FILT_LEN synchronised samples it
  // has seen (y_in taken at edges n-SS-FL+1 .. n-SS) all equal v.
  // --------------------------------------------------------------------------
  bit hist[$];
  int n_edge;
  bit m_sync[NI];
  bit m_filt[NI];
  bit m_req[NI];
  bit m_ovf[NI];
  int m_cnt[NI];

  function automatic bit smp(input int m);
    return (m >= 1) ? hist[m-1] : 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit all1;
    bit all0;
    bit ev;
    int cap;
    if (!rst_n) begin
      hist.delete();
      n_edge = 0;
      for (int i = 0; i < NI; i++) begin
        m_sync[i] = 1'b0;
        m_filt[i] = 1'b0;
        m_req[i]  = 1'b0;
        m_ovf[i]  = 1'b0;
        m_cnt[i]  = 0;
      end
    end else begin
      n_edge++;
      hist.push_back(y_in);
      for (int i = 0; i < NI; i++) begin
        all1 = 1'b1;
        all0 = 1'b1;
        ev   = 1'b0;
        for (int k = n_edge - ss[i] - fl[i] + 1; k <= n_edge - ss[i]; k++) begin
          if (smp(k)) all0 = 1'b0;
          else        all1 = 1'b0;
        end
        if (all1 && !m_filt[i]) begin
          m_filt[i] = 1'b1;
          ev        = 1'b1;
        end else if (all0 && m_filt[i]) begin
          m_filt[i] = 1'b0;
        end
        if (ev)       m_req[i] = 1'b1;
        else if (ack) m_req[i] = 1'b0;
        cap = (1 << cw[i]) - 1;
        if (clr) begin
          m_cnt[i] = ev ? 1 : 0;
          m_ovf[i] = 1'b0;
        end else if (ev) begin
          if (m_cnt[i] == cap) m_ovf[i] = 1'b1;
          else                 m_cnt[i] = m_cnt[i] + 1;
        end
        m_sync[i] = smp(n_edge - ss[i] + 1);
      end
    end
  end

  task automatic check_all(input string ph);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s.y_sync[%0d]", ph, i), d_sync[i], m_sync[i]);
      chk($sformatf("%s.y_filt[%0d]", ph, i), d_filt[i], m_filt[i]);
      chk($sformatf("%s.req[%0d]", ph, i), d_req[i], m_req[i]);
      chk($sformatf("%s.count[%0d]", ph, i), d_cnt[i], m_cnt[i]);
      chk($sformatf("%s.overflow[%0d]", ph, i), d_ovf[i], m_ovf[i]);
    end
  endtask

  // Random segments of y_in with lengths lo..hi; ack/clr with 1/ack_div, 1/clr_div odds
  task automatic run_random(input string ph, input int cycles, input int lo, input int hi,
                            input int ack_div, input int clr_div);
    int seg;
    seg = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check_all(ph);
      if (seg == 0) begin
        y_in = ~y_in;
        seg  = $urandom_range(hi, lo);
      end
      seg--;
      ack = (ack_div > 0) ? ($urandom_range(ack_div - 1, 0) == 0) : 1'b0;
      clr = (clr_div > 0) ? ($urandom_range(clr_div - 1, 0) == 0) : 1'b0;
    end
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge
  task automatic mid_reset(input string ph);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s.async_req[%0d]", ph, i), d_req[i], 0);
      chk($sformatf("%s.async_cnt[%0d]", ph, i), d_cnt[i], 0);
      chk($sformatf("%s.async_filt[%0d]", ph, i), d_filt[i], 0);
      chk($sformatf("%s.async_sync[%0d]", ph, i), d_sync[i], 0);
      chk($sformatf("%s.async_ovf[%0d]", ph, i), d_ovf[i], 0);
    end
    y_in = 1'b1;
    ack  = 1'b0;
    clr  = 1'b0;
    @(negedge clk);
    check_all({ph, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Latency from a clean step on y_in
    y_in = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      check_all("latency");
      chk($sformatf("latency.ysync0.e%0d", e), d_sync[0], (e >= 2) ? 1 : 0);
      chk($sformatf("latency.req0.e%0d", e), d_req[0], (e >= 5) ? 1 : 0);
      chk($sformatf("latency.req1.e%0d", e), d_req[1], (e >= 3) ? 1 : 0);
      chk($sformatf("latency.req2.e%0d", e), d_req[2], (e >= 7) ? 1 : 0);
    end
    repeat (12) begin
      @(negedge clk);
      check_all("hold");
    end
    chk("hold.count0", d_cnt[0], 1);

    // Short glitches: only the FILT_LEN=1 instance may see events
    run_random("glitch", 400, 1, 2, 0, 0);

    // Clean long pulses, no ack, to accumulate and saturate
    run_random("clean", 600, 10, 10, 0, 0);

    // Mixed widths, no clear, long enough to saturate the 8-bit counter
    run_random("mixed", 6000, 1, 12, 6, 0);

    // Mixed widths with clears and acks
    run_random("clears", 1500, 1, 10, 4, 8);

    // Reset in the middle of activity, with y_in held high through release
    for (int r = 0; r < 3; r++) begin
      run_random($sformatf("pre_rst%0d", r), 200 + $urandom_range(50, 0), 1, 9, 8, 40);
      mid_reset($sformatf("rst%0d", r));
      for (int e = 1; e <= 10; e++) begin
        @(negedge clk);
        check_all($sformatf("release%0d", r));
      end
      chk($sformatf("release%0d.count0", r), d_cnt[0], 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/or_event_catcher.md
Name: or_event_catcher

Overview:
Downstream capture stage for the switch-level 2-input OR gate. It takes the raw, asynchronous OR output `y`, synchronises and debounces it, and detects its rising edges as events. It presents each event as a level request held until acknowledged, and keeps a saturating event count for the control logic that consumes the combined request.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on y_in (legal 2..4)
FILT_LEN, 3, consecutive equal samples of y_sync needed to change y_filt (legal 1..15)
CNT_W, 8, width of event counter (legal 2..16)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
y_in  input  1  raw OR-gate output, asynchronous to clk
ack  input  1  consumer acknowledge of pending request, synchronous
clr  input  1  synchronous clear of count and overflow
y_sync  output  1  last synchroniser stage
y_filt  output  1  debounced level
req  output  1  pending-event request, held until ack
count  output  CNT_W  number of accepted rising events, saturating
overflow  output  1  sticky, set when an event arrives with count at all-ones

Behaviour:
- Reset (rst_n=0, asynchronous): all sync flops 0, filter FSM LOW, filter counter 0.
  - Outputs: y_sync=0, y_filt=0, req=0, count=0, overflow=0.
  - Release is synchronous to the next clk edge; no event may be generated by the reset release itself.
- Synchroniser: a SYNC_STAGES-deep shift register clocked by clk; y_sync is the last stage.
- Filter FSM, 4 states, filter counter fc of 4 bits:
  - LOW (y_filt=0):
    - y_sync=1 and FILT_LEN=1 -> HIGH.
    - y_sync=1 otherwise -> RISE_CHK, fc=1.
  - RISE_CHK (y_filt=0):
    - y_sync=0 -> LOW, fc=0.
    - y_sync=1 and fc==FILT_LEN-1 -> HIGH; event pulse asserted internally for that transition.
    - Otherwise fc++.
  - HIGH (y_filt=1): mirror of LOW toward FALL_CHK.
  - FALL_CHK (y_filt=1):
    - y_sync=1 -> HIGH.
    - y_sync=0 and fc==FILT_LEN-1 -> LOW; no event on falling edges.
    - Otherwise fc++.
- y_filt is registered; it changes on the same edge as the state change into HIGH or LOW.
- Latency: y_in stable high before edge 0 -> y_sync=1 after edge SYNC_STAGES-1 -> y_filt=1 and req=1 after edge SYNC_STAGES+FILT_LEN-1. Default: req high after the 5th edge from sampling.
- Glitch rule: a y_in pulse shorter than FILT_LEN clock periods, once synchronised, never changes y_filt and never counts.
- req handshake:
  - Set on the edge where event=1.
  - Cleared on an edge where ack=1 and event=0.
  - event=1 and ack=1 on the same edge -> req stays 1 (the new event wins).
  - ack with req=0 is ignored.
  - Events arriving while req=1 keep req=1 and are still counted.
- count/overflow:
  - On event: if count != all-ones, count++; else count holds and overflow=1.
  - clr=1: count=0, overflow=0.
  - clr=1 and event=1 on the same edge: count=1, overflow=0.
  - clr does not affect req or the filter.
- Reset mid-operation: every register returns to its reset value immediately, whatever the state; pending req is lost.
- y_in is the only asynchronous input; ack and clr are synchronous and need no synchronisation.

Test Plan:
1. Reset, then y_in=1 held 20 cycles (defaults) -> y_sync=1 after 2nd edge, y_filt=1 and req=1 after 5th edge, count=1, overflow=0.
2. y_in high 2 cycles then low (defaults) -> y_filt stays 0, req=0, count=0. Repeat with FILT_LEN=1 -> req=1, count=1.
3. req=1, pulse ack one cycle -> req=0 next edge. Then a new event on the same edge as ack=1 -> req stays 1, count increments by 1.
4. Ten clean y_in pulses (10 cycles high, 10 low) with no ack -> req stays 1 throughout, count=10, y_filt toggles 10 times.
5. CNT_W=2, five events -> count=3 saturated, overflow=1. Then clr -> count=0, overflow=0. Then clr coincident with an event -> count=1.
6. Assert rst_n=0 asynchronously mid-RISE_CHK with req=1 and count=7 -> all outputs 0 before the next clk edge. y_in held high through release -> exactly one event, req=1 after SYNC_STAGES+FILT_LEN edges.
